// File: rtl/ball_renderer.sv
// Ball position owner and rasteriser: moves the ball once per frame and emits a
// registered pixel strobe one clock behind the incoming sync, with X from the hit detector.
module ball_renderer #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SIZE     = 8,
  parameter int SPEED    = 2,
  parameter int X_INIT   = 316,
  parameter int Y_INIT   = 236
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_HReset,
  input  logic i_VReset,
  input  logic i_HBlank,
  input  logic i_XDir,
  output logic o_Ball,
  output logic o_HReset,
  output logic o_HBlank,
  output logic o_YDir
);

  // Right limit lets the last ball column land on the first blanking column.
  localparam logic [CW:0]   X_MAX  = (CW+1)'(H_ACTIVE - SIZE + 1);
  localparam logic [CW:0]   Y_MAX  = (CW+1)'(V_ACTIVE - SIZE);
  localparam logic [CW:0]   SIZE_W = (CW+1)'(SIZE);
  localparam logic [CW:0]   SPD_W  = (CW+1)'(SPEED);
  localparam logic [CW-1:0] CMAX   = '1;

  logic [CW-1:0] col, row, bx, by;
  logic          ydir;

  logic [CW-1:0] ecol, erow, col_next;
  logic [CW:0]   ecol_w, erow_w, bx_w, by_w;
  logic [CW:0]   x_up, x_dn, y_up, y_dn, nx, ny;
  logic          hit_x, hit_y;

  always_comb begin
    ecol = i_HReset ? '0 : col;
    col_next = (ecol == CMAX) ? ecol : ecol + 1'b1;

    if (i_VReset)
      erow = '0;
    else if (i_HReset)
      erow = (row == CMAX) ? row : row + 1'b1;
    else
      erow = row;

    ecol_w = {1'b0, ecol};
    erow_w = {1'b0, erow};
    bx_w   = {1'b0, bx};
    by_w   = {1'b0, by};

    // Widened compares so bx+SIZE near the counter limit cannot wrap.
    hit_x = (ecol_w >= bx_w) && (ecol_w < bx_w + SIZE_W);
    hit_y = (erow_w >= by_w) && (erow_w < by_w + SIZE_W);

    x_up = bx_w + SPD_W;
    x_dn = (bx_w < SPD_W) ? '0 : bx_w - SPD_W;
    y_up = by_w + SPD_W;
    y_dn = (by_w < SPD_W) ? '0 : by_w - SPD_W;

    if (i_XDir)
      nx = (x_up > X_MAX) ? X_MAX : x_up;
    else
      nx = x_dn;

    if (ydir)
      ny = (y_up > Y_MAX) ? Y_MAX : y_up;
    else
      ny = y_dn;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      bx       <= CW'(X_INIT);
      by       <= CW'(Y_INIT);
      ydir     <= 1'b1;
      col      <= '0;
      row      <= '0;
      o_Ball   <= 1'b0;
      o_HReset <= 1'b0;
      o_HBlank <= 1'b0;
    end else begin
      col      <= col_next;
      row      <= erow;
      o_Ball   <= hit_x && hit_y;
      o_HReset <= i_HReset;
      o_HBlank <= i_HBlank;
      // The hit test above still sees the old position in this cycle.
      if (i_VReset) begin
        bx <= nx[CW-1:0];
        by <= ny[CW-1:0];
        if (ny == Y_MAX)
          ydir <= 1'b0;
        else if (ny == '0)
          ydir <= 1'b1;
      end
    end
  end

  assign o_YDir = ydir;

endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
Owns the ball's position and draws it into the raster. It consumes the X direction flag from the hit detector and produces the ball pixel strobe that the hit detector samples, which closes the bounce loop. Position updates once per frame. Y bouncing is handled internally because there is no separate vertical hit detector. Sits between the sync generator and the pixel mux / hit detector.

Parameters:
CW, 10, width of the column/row counters and the position registers
H_ACTIVE, 640, visible columns per line
V_ACTIVE, 480, visible rows per frame
SIZE, 8, ball edge length in pixels (square)
SPEED, 2, pixels moved per frame per axis
X_INIT, 316, X position after reset
Y_INIT, 236, Y position after reset

Ports:
i_Clk  in  1  pixel clock; all logic on the rising edge
i_Reset  in  1  synchronous, active-high reset
i_HReset  in  1  one-clock pulse marking column 0 of each line
i_VReset  in  1  one-clock pulse marking row 0 of each frame; coincides with an i_HReset
i_HBlank  in  1  high during horizontal blanking
i_XDir  in  1  X direction from hit detector; 1 = right (+X), 0 = left (-X)
o_Ball  out  1  registered ball pixel strobe
o_HReset  out  1  i_HReset delayed one clock, aligned with o_Ball
o_HBlank  out  1  i_HBlank delayed one clock, aligned with o_Ball
o_YDir  out  1  internal Y direction; 1 = down (+Y), 0 = up

Behaviour:
- Reset (i_Reset=1 at a rising edge):
  - bx=X_INIT, by=Y_INIT, ydir=1.
  - col=0, row=0.
  - o_Ball=0, o_HReset=0, o_HBlank=0.
  - i_Reset overrides every other input in the same cycle.
- Effective column:
  - ecol = 0 when i_HReset=1, else col.
  - Register update: col <= ecol+1, saturating at 2^CW-1.
- Effective row:
  - erow = 0 when i_VReset=1.
  - erow = row+1 (saturating) when i_HReset=1 and i_VReset=0.
  - erow = row otherwise.
  - Register update: row <= erow.
- Hit test: hit = (bx <= ecol < bx+SIZE) AND (by <= erow < by+SIZE).
  - Compare at CW+1 bits so bx+SIZE cannot wrap.
  - Not gated by i_HBlank. The ball must be visible to the hit detector during blanking.
- Output timing:
  - o_Ball <= hit; o_HReset <= i_HReset; o_HBlank <= i_HBlank.
  - Fixed latency of 1 clock. All three outputs stay mutually aligned.
- Bounds:
  - X_MAX = H_ACTIVE-SIZE+1, so at the right limit the last ball column overlaps the first blanking column. This produces the right-edge hit.
  - Y_MAX = V_ACTIVE-SIZE.
- Position update, only in a cycle with i_VReset=1, using i_XDir sampled in that cycle:
  - X: i_XDir=1 gives bx <= min(bx+SPEED, X_MAX); i_XDir=0 gives bx <= max(bx-SPEED, 0). Arithmetic saturates; no wrap or underflow.
  - Y: ydir=1 gives ny = min(by+SPEED, Y_MAX); ydir=0 gives ny = max(by-SPEED, 0). Then by <= ny.
  - If ny==Y_MAX then ydir <= 0. If ny==0 then ydir <= 1. The flip happens in the same cycle as the move.
- The hit test in the i_VReset cycle uses the old bx/by. The new position takes effect from the next cycle.
- i_XDir changing mid-frame has no effect until the next i_VReset.
- If i_HReset is missing, col saturates and o_Ball stays 0 until a pulse arrives.
- o_YDir = ydir (direct from register).

Test Plan:
- Reset: assert i_Reset 2 clocks, then run one frame with no i_VReset.
  - o_Ball=1 exactly on rows 236..243, ecol 316..323, each one clock late.
  - o_YDir=1; o_HReset/o_HBlank are 1-clock-delayed copies of the inputs.
- X motion: i_XDir=1, 3 i_VReset pulses → bx=322; then i_XDir=0, 1 pulse → bx=320.
  - Check o_Ball first asserts 1 clock after ecol==322, then after ecol==320.
- Right saturation: bx=632, i_XDir=1, one i_VReset → bx=633 (clamped).
  - o_Ball stays high on ecol=640, overlapping o_HBlank=1 in the same cycle.
- Left saturation: bx=1, i_XDir=0, one i_VReset → bx=0.
  - On ball rows, o_Ball=1 in the same cycle as o_HReset=1.
- Y bounce: by=471, ydir=1, one i_VReset → by=472, o_YDir=0. Next pulse → by=470.
  - Mirror case: by=1, ydir=0 → by=0, o_YDir=1.
- Mid-frame reset: assert i_Reset while o_Ball=1.
  - The next clock shows o_Ball=0 and bx/by back at 316/236.
  - An i_VReset in the same cycle as i_Reset causes no move.
